// File: rtl/fetch_mem_pf.sv
// fetch_mem_pf: loadable instruction store with WAIT_CYCLES access latency and a sequential prefetch buffer
module fetch_mem_pf #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2,
  parameter int PF_DEPTH    = 4
) (
  input  logic              clk_fetch,
  input  logic              reset_mem_fetch_n,
  input  logic [31:0]       pc_m,
  input  logic              fetch,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] out_mbr,
  output logic              mbr_valid,
  output logic              busy,
  output logic              addr_err,
  output logic [31:0]       debug_pc
);
  localparam int PW = $clog2(PF_DEPTH);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [PW:0] PF = (PW+1)'(PF_DEPTH);
  typedef enum logic [1:0] {IDLE, MISS, PREF} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] buf_a [PF_DEPTH];
  logic [DATA_W-1:0] buf_d [PF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] occ, occ_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_W:0] pf_addr, pf_addr_n;
  logic [ADDR_W-1:0] miss_addr;
  logic load_ok, take, range_err, hit, miss, done, deliver, flush, push;
  assign debug_pc  = pc_m;
  assign busy      = state == MISS;
  assign load_ok   = load_en && ({1'b0, load_addr} < DEPTH_P);
  assign take      = fetch && !busy;
  assign range_err = take && pc_m >= 32'(DEPTH);
  assign hit       = take && !range_err && !load_ok && occ != '0 && pc_m == 32'(buf_a[head]);
  assign miss      = take && !range_err && !hit;
  assign done      = cnt == CW'(WAIT_CYCLES - 1);
  assign deliver   = busy && done && !load_ok;
  assign flush     = load_ok || range_err || miss;
  assign push      = state == PREF && done && !flush;
  assign occ_n     = flush ? '0 : occ + (PW+1)'(push) - (PW+1)'(hit);
  // a load while a demand read is pending restarts it so the returned byte is post-write
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    pf_addr_n = pf_addr;
    if (miss) begin
      state_n = MISS;
      cnt_n   = '0;
    end else if (range_err || load_ok) begin
      state_n = busy ? MISS : IDLE;
      cnt_n   = '0;
    end else if (state == MISS) begin
      if (done) begin
        pf_addr_n = {1'b0, miss_addr} + (ADDR_W+1)'(1);
        state_n   = pf_addr_n < DEPTH_P ? PREF : IDLE;
        cnt_n     = '0;
      end
    end else if (state == PREF) begin
      if (done) begin
        pf_addr_n = pf_addr + (ADDR_W+1)'(1);
        state_n   = (occ_n == PF || pf_addr_n == DEPTH_P) ? IDLE : PREF;
        cnt_n     = '0;
      end
    end else begin
      cnt_n   = '0;
      state_n = (occ_n < PF && pf_addr < DEPTH_P) ? PREF : IDLE;
    end
  end
  // pf_addr parks at DEPTH out of reset so nothing is prefetched before the first miss
  always_ff @(posedge clk_fetch or negedge reset_mem_fetch_n) begin
    if (!reset_mem_fetch_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pf_addr   <= DEPTH_P;
      miss_addr <= '0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      out_mbr   <= '0;
      mbr_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pf_addr   <= pf_addr_n;
      occ       <= occ_n;
      mbr_valid <= hit || deliver;
      addr_err  <= range_err;
      head      <= flush ? '0 : head + PW'(hit);
      tail      <= flush ? '0 : tail + PW'(push);
      if (miss) miss_addr <= pc_m[ADDR_W-1:0];
      if (range_err) out_mbr <= '0;
      else if (hit) out_mbr <= buf_d[head];
      else if (deliver) out_mbr <= mem[miss_addr];
    end
  end
  always_ff @(posedge clk_fetch) begin
    if (load_ok) mem[load_addr] <= load_data;
    if (push) begin
      buf_a[tail] <= pf_addr[ADDR_W-1:0];
      buf_d[tail] <= mem[pf_addr[ADDR_W-1:0]];
    end
  end
endmodule

// File: tb/tb_fetch_mem_pf.sv
// tb_fetch_mem_pf: directed table plus randomized traffic against a queue-based reference model
module tb_fetch_mem_pf;
  localparam int DEPTH = 64;
  localparam int ADDR_W = 6;
  localparam int WAIT = 2;
  localparam int PF = 4;
  logic clk_fetch = 1'b0;
  logic reset_mem_fetch_n;
  logic [31:0] pc_m;
  logic fetch, load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0] load_data, out_mbr;
  logic mbr_valid, busy, addr_err;
  logic [31:0] debug_pc;
  int checks = 0;
  int errors = 0;
  fetch_mem_pf #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT), .PF_DEPTH(PF)) dut (
    .clk_fetch(clk_fetch), .reset_mem_fetch_n(reset_mem_fetch_n), .pc_m(pc_m), .fetch(fetch),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .out_mbr(out_mbr),
    .mbr_valid(mbr_valid), .busy(busy), .addr_err(addr_err), .debug_pc(debug_pc)
  );
  always #5 clk_fetch = ~clk_fetch;
  typedef struct { int a; logic [7:0] d; } ent_t;
  ent_t q[$];
  logic [7:0] mem_m [DEPTH];
  int miss_left, pf_left, miss_addr, pf_addr;
  logic [7:0] m_out;
  bit m_valid, m_err, m_busy;
  typedef struct { bit le; int la; int ld; bit f; int pc; bit v; int mbr; bit b; bit e; } vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    miss_left = 0; pf_left = 0; miss_addr = 0; pf_addr = DEPTH;
    m_out = 0; m_valid = 0; m_err = 0; m_busy = 0;
  endtask
  // one rising edge worth of behaviour: load first, then fetch, then background progress
  task automatic model_edge(input bit le, input int la, input logic [7:0] ld, input bit f, input int pc);
    bit busy0, hold;
    busy0 = miss_left > 0; hold = 0; m_valid = 0; m_err = 0;
    if (le && la < DEPTH) begin
      mem_m[la] = ld; q.delete(); pf_left = 0; hold = 1;
      if (busy0) miss_left = WAIT;
    end
    if (f && !busy0) begin
      if (pc >= DEPTH) begin
        m_out = 0; m_err = 1; q.delete(); pf_left = 0; hold = 1;
      end else if (q.size() > 0 && q[0].a == pc) begin
        m_out = q[0].d; m_valid = 1; void'(q.pop_front());
      end else begin
        q.delete(); pf_left = 0; miss_addr = pc; miss_left = WAIT; hold = 1;
      end
    end
    if (!hold) begin
      if (miss_left > 0) begin
        miss_left--;
        if (miss_left == 0) begin
          m_out = mem_m[miss_addr]; m_valid = 1; pf_addr = miss_addr + 1;
          if (pf_addr < DEPTH) pf_left = WAIT;
        end
      end else if (pf_left > 0) begin
        pf_left--;
        if (pf_left == 0) begin
          q.push_back('{pf_addr, mem_m[pf_addr]});
          pf_addr++;
          if (q.size() < PF && pf_addr < DEPTH) pf_left = WAIT;
        end
      end else if (q.size() < PF && pf_addr < DEPTH) pf_left = WAIT;
    end
    m_busy = miss_left > 0;
  endtask
  task automatic cyc(input bit le, input int la, input int ld, input bit f, input int pc);
    load_en = le; load_addr = la[ADDR_W-1:0]; load_data = ld[7:0]; fetch = f; pc_m = pc;
    @(posedge clk_fetch); #1;
    model_edge(le, la, ld[7:0], f, pc);
    chk("mbr", out_mbr, m_out);
    chk("valid", mbr_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("addr_err", addr_err, m_err);
    chk("debug_pc", debug_pc, pc);
  endtask
  function automatic void add(bit le, int la, int ld, bit f, int pc, bit v, int mbr, bit b, bit e);
    tbl.push_back('{le, la, ld, f, pc, v, mbr, b, e});
  endfunction
  function automatic void nops(int n, int mbr);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, mbr, 0, 0);
  endfunction
  initial begin
    int r, s, pc;
    bit bp, f;
    reset_mem_fetch_n = 0; pc_m = 0; fetch = 0; load_en = 0; load_addr = 0; load_data = 0;
    model_reset();
    repeat (2) @(posedge clk_fetch);
    #1;
    chk("rst_mbr", out_mbr, 0);
    chk("rst_valid", mbr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", addr_err, 0);
    reset_mem_fetch_n = 1;
    for (int i = 0; i < DEPTH; i++) cyc(1, i, i ^ 'h5a, 0, 0);
    for (int i = 0; i < 8; i++) add(1, i, 'h10 + i, 0, 0, 0, 0, 0, 0);
    add(1, 62, 'h3e, 0, 0, 0, 0, 0, 0);
    add(1, 63, 'h3f, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 'h10, 0, 0);
    nops(8, 'h10);
    for (int i = 1; i < 5; i++) add(0, 0, 0, 1, i, 1, 'h10 + i, 0, 0);
    add(0, 0, 0, 1, 6, 0, 'h14, 1, 0);
    add(0, 0, 0, 0, 0, 0, 'h14, 1, 0);
    add(0, 0, 0, 0, 0, 1, 'h16, 0, 0);
    nops(2, 'h16);
    add(0, 0, 0, 1, 7, 1, 'h17, 0, 0);
    add(0, 0, 0, 1, 64, 0, 0, 0, 1);
    nops(1, 0);
    add(0, 0, 0, 1, 62, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 'h3e, 0, 0);
    nops(2, 'h3e);
    add(0, 0, 0, 1, 63, 1, 'h3f, 0, 0);
    nops(3, 'h3f);
    add(0, 0, 0, 1, 1, 0, 'h3f, 1, 0);
    add(0, 0, 0, 0, 0, 0, 'h3f, 1, 0);
    add(0, 0, 0, 0, 0, 1, 'h11, 0, 0);
    nops(4, 'h11);
    add(1, 2, 'haa, 0, 0, 0, 'h11, 0, 0);
    add(0, 0, 0, 1, 2, 0, 'h11, 1, 0);
    add(0, 0, 0, 0, 0, 0, 'h11, 1, 0);
    add(0, 0, 0, 0, 0, 1, 'haa, 0, 0);
    add(1, 5, 'h55, 1, 5, 0, 'haa, 1, 0);
    add(0, 0, 0, 0, 0, 0, 'haa, 1, 0);
    add(0, 0, 0, 0, 0, 1, 'h55, 0, 0);
    add(0, 0, 0, 1, 10, 0, 'h55, 1, 0);
    add(1, 10, 'h77, 0, 0, 0, 'h55, 1, 0);
    add(0, 0, 0, 1, 3, 0, 'h55, 1, 0);
    add(0, 0, 0, 0, 0, 1, 'h77, 0, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].le, tbl[i].la, tbl[i].ld, tbl[i].f, tbl[i].pc);
      chk($sformatf("t%0d_mbr", i), out_mbr, tbl[i].mbr);
      chk($sformatf("t%0d_valid", i), mbr_valid, tbl[i].v);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("t%0d_err", i), addr_err, tbl[i].e);
    end
    cyc(0, 0, 0, 1, 20);
    chk("pre_rst_busy", busy, 1);
    reset_mem_fetch_n = 0;
    #2;
    chk("midrst_mbr", out_mbr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", mbr_valid, 0);
    model_reset();
    repeat (2) @(posedge clk_fetch);
    #1;
    reset_mem_fetch_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("post_rst_valid", mbr_valid, 0);
      chk("post_rst_mbr", out_mbr, 0);
    end
    pc = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 19);
      f = $urandom_range(0, 3) != 0;
      if (s == 0) pc = $urandom_range(DEPTH, DEPTH + 3);
      else if (s < 3) pc = $urandom_range(0, DEPTH - 1);
      bp = m_busy;
      cyc(r < 6, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255), f, pc);
      if (f && !bp) pc = pc + 1 >= DEPTH ? 0 : pc + 1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_mem_pf.md
Name: fetch_mem_pf

Overview:
- Parametrised successor to the MIC fetch memory: byte-wide, loadable instruction store with configurable access latency and a sequential prefetch buffer.
- Sits between the MIC datapath (PC/MBR, fetch strobe) and the program store.
- Serves sequential fetches from the buffer in 1 cycle. Non-sequential fetches (branches) flush the buffer and pay full memory latency.
- Adds a load port so programs are written at run time instead of being hard-coded.

Parameters:
- DATA_W, 8: instruction byte width (MBR width).
- DEPTH, 64: number of words in the store.
- ADDR_W, 6: store address width; DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 2: store access latency in cycles, >= 1.
- PF_DEPTH, 4: prefetch buffer entries, power of two, >= 2.

Ports:
- clk_fetch  in  1  clock; all state updates on the rising edge.
- reset_mem_fetch_n  in  1  asynchronous, active-low reset.
- pc_m  in  32  fetch address (PC).
- fetch  in  1  fetch request, sampled on the rising edge.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  program-load address.
- load_data  in  DATA_W  program-load data.
- out_mbr  out  DATA_W  fetched byte; holds its value until the next delivery.
- mbr_valid  out  1  one-cycle pulse when out_mbr is updated.
- busy  out  1  demand miss in progress; fetch is ignored while high.
- addr_err  out  1  one-cycle pulse on a fetch with pc_m >= DEPTH.
- debug_pc  out  32  combinational copy of pc_m.

Behaviour:
- Reset (asynchronous, active-low):
  - out_mbr=0, mbr_valid=0, busy=0, addr_err=0.
  - Buffer emptied, state IDLE, access counter 0.
  - Store contents are not reset.
- State machine:
  - IDLE: no access running.
  - MISS: demand read of pc_m; busy=1.
  - PREF: background read of pf_addr.
  - An access counter counts WAIT_CYCLES edges per read in MISS/PREF.
- Fetch evaluation order when fetch=1 and busy=0:
  1. Range check: if pc_m >= DEPTH, then at the sampling edge out_mbr<=0, addr_err pulses, the buffer flushes, any PREF read aborts, and the FSM goes to IDLE.
  2. Hit: buffer non-empty and head address == pc_m. At the sampling edge out_mbr<=head data, mbr_valid pulses, and the head pops. Latency is 1 cycle.
  3. Miss (otherwise):
     - The buffer flushes and any PREF read aborts.
     - FSM goes to MISS and busy rises after the sampling edge k.
     - At edge k+WAIT_CYCLES: out_mbr<=mem[pc_m latched at k], mbr_valid pulses, busy falls.
     - pf_addr<=pc_m+1 and the FSM goes to PREF.
- Prefetch:
  - In IDLE, the FSM enters PREF when the buffer is not full and pf_addr < DEPTH.
  - Each PREF read takes WAIT_CYCLES cycles. On completion it pushes {pf_addr, data} and pf_addr increments.
  - When the buffer is full or pf_addr == DEPTH, the FSM returns to IDLE. There is no wrap-around.
  - A hit pop and a prefetch push on the same edge leave the occupancy unchanged.
  - A push into a full buffer never occurs: no PREF read starts when full.
- Load port:
  - load_en writes mem[load_addr]<=load_data at the edge.
  - The same edge flushes the buffer, aborts PREF, and returns the FSM to IDLE for coherency.
  - load_en during MISS restarts the counter, so the demand read returns post-write data.
  - load_en and fetch on the same edge: the write applies first, and the fetch is then treated as a miss.
  - load_addr >= DEPTH is ignored: no write, no flush.
- fetch while busy=1 is ignored; no queueing.
- mbr_valid and addr_err are never high together.
- Reset asserted mid-MISS/PREF: immediate abort, all outputs to reset values, no mbr_valid after release.

Test Plan:
- Reset, then load 0x00..0x07 with bytes 0x10..0x17; fetch pc=0 at edge k.
  - busy high for 2 cycles; out_mbr=0x10 with mbr_valid at k+2.
- Continue fetching pc=1,2,3,4 each cycle once the buffer is filled (wait 8 cycles).
  - Each returns 0x11..0x14 with 1-cycle latency; busy stays 0.
- With the buffer holding pc 1..4, fetch pc=6.
  - Flush; miss; 0x16 after 2 cycles.
  - A subsequent fetch of pc=7 hits after prefetch.
- With DEPTH=64, fetch pc=64 -> addr_err pulses, out_mbr=0, no busy.
- Fetch pc=62 -> miss returns mem[62]; prefetch stops after pc=63 (one entry); fetch pc=63 hits.
- Load mem[2]=0xAA while pc 2 is buffered, then fetch pc=2.
  - Miss (buffer flushed), returns 0xAA.
  - Assert reset mid-miss: no mbr_valid after release; out_mbr=0.
